// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman target feeder:
// nucleotide codes, biased-zero helper and the feeder FSM encoding.
package sw_pkg;

    localparam logic [1:0] NT_A = 2'b00;
    localparam logic [1:0] NT_G = 2'b01;
    localparam logic [1:0] NT_T = 2'b10;
    localparam logic [1:0] NT_C = 2'b11;

    // Scores travel biased so that "zero" sits at the midpoint of the bus.
    function automatic int unsigned zero(input int unsigned score_width);
        return 32'd1 << (score_width - 1);
    endfunction

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        LOAD   = 6'b000010,
        STREAM = 6'b000100,
        GAP    = 6'b001000,
        DRAIN  = 6'b010000,
        RESULT = 6'b100000
    } sw_state_t;

endpackage

// File: rtl/sw_base_buffer.sv
// Target base store: simple dual-port RAM, 2-bit entries, registered read.
// The read register doubles as the PE0 data register and idles at base A (00).
module sw_base_buffer
    import sw_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= NT_A;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= NT_A;
        end
    end

endmodule

// File: rtl/sw_target_feeder.sv
// Feeds one buffered target sequence into PE0 of the Smith-Waterman array and
// returns the last PE's unbiased high score on a valid/ready result port.
//
// state  | meaning
// IDLE   | waiting for the first base of a target
// LOAD   | buffering bases until s_last (extra bases past MAX_TLEN dropped)
// STREAM | one priming read, then pe_en high for len cycles
// GAP    | first pe_en=0 cycle, timeout counter cleared
// DRAIN  | waiting for the last PE's valid pulse or the timeout
// RESULT | result held until r_ready
module sw_target_feeder
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH = 12,
    parameter int ARRAY_LEN   = 128,
    parameter int MAX_TLEN    = 1024,
    parameter int TLEN_W      = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             s_base,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [1:0]             pe_data,
    output logic                   pe_en,
    output logic [SCORE_WIDTH-1:0] pe_M,
    output logic [SCORE_WIDTH-1:0] pe_I,
    output logic [SCORE_WIDTH-1:0] pe_High,
    input  logic [SCORE_WIDTH-1:0] pe_High_in,
    input  logic                   pe_vld_in,
    output logic [SCORE_WIDTH-1:0] r_score,
    output logic [TLEN_W-1:0]      r_len,
    output logic                   r_err,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic                   busy
);

    localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(zero(SCORE_WIDTH));
    localparam int AW       = (MAX_TLEN > 1) ? $clog2(MAX_TLEN) : 1;
    localparam int TO_LIMIT = ARRAY_LEN + 8;
    localparam int CNT_W    = $clog2(TO_LIMIT + 1);
    localparam logic [TLEN_W-1:0] MAX_LEN = TLEN_W'(MAX_TLEN);
    localparam logic [TLEN_W-1:0] ONE     = TLEN_W'(1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TO_LIMIT - 1);

    sw_state_t         state;
    logic [TLEN_W-1:0] wr_ptr;
    logic [TLEN_W-1:0] rd_ptr;
    logic [TLEN_W-1:0] len;
    logic [CNT_W-1:0]  to_cnt;
    logic              ovf;

    logic              accept;
    logic              buf_we;
    logic              buf_re;
    logic [AW-1:0]     buf_waddr;
    logic [SCORE_WIDTH-1:0] score_unbiased;

    assign accept = s_valid & s_ready;
    assign busy   = (state != IDLE);

    // A high score below the biased zero means no positive local alignment.
    assign score_unbiased = pe_High_in[SCORE_WIDTH-1] ? (pe_High_in - ZERO) : '0;

    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = '0;
        if (state == IDLE) begin
            buf_we = accept;
        end else if (state == LOAD) begin
            buf_we    = accept && (wr_ptr != MAX_LEN);
            buf_waddr = wr_ptr[AW-1:0];
        end
    end

    // Reads are issued one cycle ahead of the pe_en they pair with.
    assign buf_re = (state == STREAM) && (rd_ptr != len);

    sw_base_buffer #(
        .DEPTH (MAX_TLEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_addr (buf_waddr),
        .wr_data (s_base),
        .rd_en   (buf_re),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (pe_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len     <= '0;
            to_cnt  <= '0;
            ovf     <= 1'b0;
            pe_en   <= 1'b0;
            pe_M    <= ZERO;
            pe_I    <= ZERO;
            pe_High <= ZERO;
            s_ready <= 1'b0;
            r_valid <= 1'b0;
            r_score <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            pe_M    <= ZERO;
            pe_I    <= ZERO;
            pe_High <= ZERO;
            unique case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        wr_ptr <= ONE;
                        if (s_last) begin
                            len     <= ONE;
                            rd_ptr  <= '0;
                            s_ready <= 1'b0;
                            state   <= STREAM;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (wr_ptr != MAX_LEN) begin
                            wr_ptr <= wr_ptr + ONE;
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (s_last) begin
                            len     <= (wr_ptr != MAX_LEN) ? (wr_ptr + ONE) : MAX_LEN;
                            rd_ptr  <= '0;
                            s_ready <= 1'b0;
                            state   <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (rd_ptr != len) begin
                        pe_en  <= 1'b1;
                        rd_ptr <= rd_ptr + ONE;
                    end else begin
                        pe_en <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    to_cnt <= '0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    // A valid pulse on the final timeout cycle still counts.
                    if (pe_vld_in) begin
                        r_score <= score_unbiased;
                        r_len   <= len;
                        r_err   <= ovf;
                        r_valid <= 1'b1;
                        state   <= RESULT;
                    end else if (to_cnt == TO_LAST) begin
                        r_score <= '0;
                        r_len   <= len;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        state   <= RESULT;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (r_valid && r_ready) begin
                        r_valid <= 1'b0;
                        ovf     <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_target_feeder.sv
// Self-checking bench for sw_target_feeder: directed and random targets with a
// behavioural last-PE (affine-gap Smith-Waterman score, delayed valid pulse).
module tb_sw_target_feeder;

    localparam int SW   = 12;
    localparam int AL   = 4;
    localparam int MAXT = 8;
    localparam int TW   = 4;
    localparam logic [SW-1:0] ZERO = 12'h800;

    logic          clk, rst;
    logic [1:0]    s_base;
    logic          s_valid, s_last, s_ready;
    logic [1:0]    pe_data;
    logic          pe_en;
    logic [SW-1:0] pe_M, pe_I, pe_High, pe_High_in;
    logic          pe_vld_in;
    logic [SW-1:0] r_score;
    logic [TW-1:0] r_len;
    logic          r_err, r_valid, r_ready, busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] en_q[$];
    int en_runs = 0, bnd_bad = 0, idle_bad = 0, ncyc = 0, gap_cyc = -1, rv_cyc = -1;
    logic prev_en, prev_rv;
    bit vld_mode = 1'b0, vld_armed = 1'b0;
    int vld_delay = AL, vld_at = 0;
    logic [SW-1:0] vld_high = '0;
    logic [1:0] query[$];

    sw_target_feeder #(
        .SCORE_WIDTH (SW),
        .ARRAY_LEN   (AL),
        .MAX_TLEN    (MAXT),
        .TLEN_W      (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_base     (s_base),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .pe_data    (pe_data),
        .pe_en      (pe_en),
        .pe_M       (pe_M),
        .pe_I       (pe_I),
        .pe_High    (pe_High),
        .pe_High_in (pe_High_in),
        .pe_vld_in  (pe_vld_in),
        .r_score    (r_score),
        .r_len      (r_len),
        .r_err      (r_err),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural last PE plus output monitor, all on the falling edge.
    initial begin : pe_side
        prev_en = 1'b0;
        prev_rv = 1'b0;
        pe_vld_in = 1'b0;
        pe_High_in = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (vld_armed && ncyc == vld_at) begin
                pe_vld_in  = 1'b1;
                pe_High_in = vld_high;
                vld_armed  = 1'b0;
            end else begin
                pe_vld_in = 1'b0;
            end
            if (pe_M !== ZERO || pe_I !== ZERO || pe_High !== ZERO) bnd_bad++;
            if (pe_en === 1'b1) begin
                en_q.push_back(pe_data);
                if (!prev_en) en_runs++;
            end else if (pe_data !== 2'b00) begin
                idle_bad++;
            end
            if (prev_en && pe_en === 1'b0) begin
                gap_cyc = ncyc;
                if (vld_mode) begin
                    vld_armed = 1'b1;
                    vld_at    = ncyc + vld_delay;
                end
            end
            if (r_valid === 1'b1 && !prev_rv) rv_cyc = ncyc;
            prev_en = (pe_en === 1'b1);
            prev_rv = (r_valid === 1'b1);
        end
    end

    // Local alignment score, affine gaps: match +2, mismatch -1, open -3, extend -1.
    function automatic int sw_score(input logic [1:0] qs[$], input logic [1:0] ts[$]);
        int h[16][16];
        int e[16][16];
        int f[16][16];
        int best = 0;
        int d;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                h[i][j] = 0;
                e[i][j] = -1000;
                f[i][j] = -1000;
            end
        end
        for (int i = 1; i <= qs.size(); i++) begin
            for (int j = 1; j <= ts.size(); j++) begin
                e[i][j] = (h[i][j-1] - 3 > e[i][j-1] - 1) ? h[i][j-1] - 3 : e[i][j-1] - 1;
                f[i][j] = (h[i-1][j] - 3 > f[i-1][j] - 1) ? h[i-1][j] - 3 : f[i-1][j] - 1;
                d = h[i-1][j-1] + ((qs[i-1] == ts[j-1]) ? 2 : -1);
                h[i][j] = 0;
                if (d > h[i][j]) h[i][j] = d;
                if (e[i][j] > h[i][j]) h[i][j] = e[i][j];
                if (f[i][j] > h[i][j]) h[i][j] = f[i][j];
                if (h[i][j] > best) best = h[i][j];
            end
        end
        return best;
    endfunction

    task automatic clear_mon();
        #1;
        en_q.delete();
        en_runs   = 0;
        bnd_bad   = 0;
        idle_bad  = 0;
        gap_cyc   = -1;
        rv_cyc    = -1;
        vld_armed = 1'b0;
    endtask

    task automatic send_target(input logic [1:0] bases[$], input int gaps[$], output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < bases.size(); i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_base  = bases[i];
            s_last  = (i == bases.size() - 1);
            w = 0;
            while (s_ready !== 1'b1 && w < 50) begin
                stalls++;
                w++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (r_valid === 1'b1) ok = 1'b1;
        end
        #1;
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        tests_run++;
        if (r_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_consume: r_valid=%b busy=%b, want 0 0", name, r_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({pe_en, pe_data, s_ready, r_valid, r_err, busy} !== 8'b0 ||
            r_score !== '0 || r_len !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pe_en=%b pe_data=%b s_ready=%b r_valid=%b r_err=%b busy=%b r_score=%0d r_len=%0d, want all 0",
                     pe_en, pe_data, s_ready, r_valid, r_err, busy, r_score, r_len);
        end
        tests_run++;
        if (pe_M !== ZERO || pe_I !== ZERO || pe_High !== ZERO) begin
            tests_failed++;
            $display("FAIL reset_boundary: M=%h I=%h High=%h, want 800", pe_M, pe_I, pe_High);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: s_ready=%b busy=%b, want 1 0", s_ready, busy);
        end
    endtask

    task automatic test_acgt();
        logic [1:0] b[$];
        int g[$];
        int st;
        bit ok;
        b = '{2'b00, 2'b11, 2'b01, 2'b10};
        g = '{0, 0, 0, 0};
        clear_mon();
        vld_mode = 1'b1; vld_delay = AL; vld_high = ZERO + 12'd8;
        send_target(b, g, st);
        wait_result(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL acgt_result: r_valid never rose, want 1"); end
        tests_run++;
        if (en_q.size() != 4 || en_runs != 1 ||
            (en_q.size() == 4 && (en_q[0] !== 2'b00 || en_q[1] !== 2'b11 || en_q[2] !== 2'b01 || en_q[3] !== 2'b10))) begin
            tests_failed++;
            $display("FAIL acgt_stream: %0d beats in %0d runs %p, want 4 in 1 run 00,11,01,10", en_q.size(), en_runs, en_q);
        end
        tests_run++;
        if (bnd_bad != 0 || idle_bad != 0) begin
            tests_failed++;
            $display("FAIL acgt_boundary: bad boundary samples=%0d bad idle data=%0d, want 0 0", bnd_bad, idle_bad);
        end
        tests_run++;
        if (r_score !== 12'd8 || r_len !== 4'd4 || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL acgt_score: score=%0d len=%0d err=%b, want 8 4 0", r_score, r_len, r_err);
        end
        tests_run++;
        if (rv_cyc - gap_cyc != AL + 1) begin
            tests_failed++;
            $display("FAIL acgt_latency: gap-to-valid=%0d, want %0d", rv_cyc - gap_cyc, AL + 1);
        end
        consume("acgt");
    endtask

    task automatic test_load_gaps();
        logic [1:0] b[$];
        int g[$];
        int st;
        bit ok;
        b = '{2'b10, 2'b01, 2'b11, 2'b00};
        g = '{0, 2, 0, 4};
        clear_mon();
        vld_mode = 1'b1; vld_delay = AL; vld_high = ZERO + 12'd3;
        send_target(b, g, st);
        wait_result(ok);
        tests_run++;
        if (!ok || en_runs != 1 || en_q.size() != 4) begin
            tests_failed++;
            $display("FAIL gaps_pulse: ok=%b runs=%0d beats=%0d, want 1 1 4", ok, en_runs, en_q.size());
        end
        tests_run++;
        if (en_q.size() == 4 && (en_q[0] !== 2'b10 || en_q[1] !== 2'b01 || en_q[2] !== 2'b11 || en_q[3] !== 2'b00)) begin
            tests_failed++;
            $display("FAIL gaps_data: got %p, want 10,01,11,00", en_q);
        end
        tests_run++;
        if (r_score !== 12'd3 || r_len !== 4'd4 || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL gaps_result: score=%0d len=%0d err=%b, want 3 4 0", r_score, r_len, r_err);
        end
        consume("gaps");
    endtask

    task automatic test_one_base();
        logic [1:0] b[$];
        int g[$];
        int st, exp;
        bit ok;
        b = '{2'b11};
        g = '{1};
        exp = sw_score(query, b);
        clear_mon();
        vld_mode = 1'b1; vld_delay = AL; vld_high = ZERO + SW'(exp);
        send_target(b, g, st);
        wait_result(ok);
        tests_run++;
        if (!ok || en_runs != 1 || en_q.size() != 1 || (en_q.size() == 1 && en_q[0] !== 2'b11)) begin
            tests_failed++;
            $display("FAIL one_base_pulse: ok=%b runs=%0d beats=%0d, want 1 1 1 with base 11", ok, en_runs, en_q.size());
        end
        tests_run++;
        if (r_len !== 4'd1 || r_err !== 1'b0 || r_score !== SW'(exp)) begin
            tests_failed++;
            $display("FAIL one_base_result: len=%0d err=%b score=%0d, want 1 0 %0d", r_len, r_err, r_score, exp);
        end
        consume("one_base");
    endtask

    task automatic test_overflow();
        logic [1:0] b[$];
        logic [1:0] kept[$];
        int g[$];
        int st, exp, bad;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            b.push_back(2'($urandom_range(0, 3)));
            g.push_back(0);
            if (i < MAXT) kept.push_back(b[i]);
        end
        exp = sw_score(query, kept);
        clear_mon();
        vld_mode = 1'b1; vld_delay = AL; vld_high = ZERO + SW'(exp);
        send_target(b, g, st);
        wait_result(ok);
        tests_run++;
        if (st != 0) begin
            tests_failed++;
            $display("FAIL overflow_ready: %0d stall cycles, want 0", st);
        end
        bad = (en_q.size() != MAXT || en_runs != 1) ? 1 : 0;
        for (int i = 0; i < en_q.size() && i < MAXT; i++) if (en_q[i] !== kept[i]) bad++;
        tests_run++;
        if (!ok || bad != 0) begin
            tests_failed++;
            $display("FAIL overflow_stream: ok=%b beats=%0d runs=%0d bad=%0d, want 1 %0d 1 0", ok, en_q.size(), en_runs, bad, MAXT);
        end
        tests_run++;
        if (r_len !== 4'd8 || r_err !== 1'b1 || r_score !== SW'(exp)) begin
            tests_failed++;
            $display("FAIL overflow_result: len=%0d err=%b score=%0d, want 8 1 %0d", r_len, r_err, r_score, exp);
        end
        consume("overflow");
    endtask

    task automatic test_timeout();
        logic [1:0] b[$];
        int g[$];
        int st, bad;
        bit ok;
        b = '{2'b01, 2'b01, 2'b10, 2'b00};
        g = '{0, 0, 0, 0};
        clear_mon();
        vld_mode = 1'b0;
        send_target(b, g, st);
        wait_result(ok);
        tests_run++;
        if (!ok || rv_cyc - gap_cyc != AL + 9) begin
            tests_failed++;
            $display("FAIL timeout_latency: ok=%b gap-to-valid=%0d, want 1 %0d", ok, rv_cyc - gap_cyc, AL + 9);
        end
        tests_run++;
        if (r_err !== 1'b1 || r_score !== '0 || r_len !== 4'd4) begin
            tests_failed++;
            $display("FAIL timeout_result: err=%b score=%0d len=%0d, want 1 0 4", r_err, r_score, r_len);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (r_valid !== 1'b1 || r_err !== 1'b1 || r_score !== '0 || r_len !== 4'd4 || s_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL timeout_hold: %0d unstable cycles, want 0", bad);
        end
        consume("timeout");
    endtask

    task automatic test_vld_expiry();
        logic [1:0] b[$];
        int g[$];
        int st;
        bit ok;
        b = '{2'b00, 2'b10};
        g = '{0, 1};
        clear_mon();
        vld_mode = 1'b1; vld_delay = AL + 8; vld_high = ZERO + 12'd5;
        send_target(b, g, st);
        wait_result(ok);
        tests_run++;
        if (!ok || r_err !== 1'b0 || r_score !== 12'd5 || rv_cyc - gap_cyc != AL + 9) begin
            tests_failed++;
            $display("FAIL expiry_vld_wins: ok=%b err=%b score=%0d latency=%0d, want 1 0 5 %0d",
                     ok, r_err, r_score, rv_cyc - gap_cyc, AL + 9);
        end
        consume("expiry");
    endtask

    task automatic test_reset_stream();
        logic [1:0] b[$];
        int g[$];
        int st, w;
        b = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01};
        g = '{0, 0, 0, 0, 0, 0, 0, 0};
        clear_mon();
        vld_mode = 1'b0;
        send_target(b, g, st);
        w = 0;
        while (pe_en !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (w >= 20 || pe_en !== 1'b0 || busy !== 1'b0 || r_valid !== 1'b0 || pe_data !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_stream: wait=%0d pe_en=%b busy=%b r_valid=%b pe_data=%b, want <20 0 0 0 00",
                     w, pe_en, busy, r_valid, pe_data);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stream_idle: s_ready=%b busy=%b, want 1 0", s_ready, busy);
        end
    endtask

    task automatic test_random();
        logic [1:0] b[$];
        logic [1:0] kept[$];
        int g[$];
        int n, d, st, exp_len, exp_score, exp_lat, bad;
        bit caught, ok, exp_err;
        logic [SW-1:0] hi;
        for (int it = 0; it < 25; it++) begin
            b.delete(); kept.delete(); g.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                b.push_back(2'($urandom_range(0, 3)));
                g.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
                if (i < MAXT) kept.push_back(b[i]);
            end
            exp_len = (n > MAXT) ? MAXT : n;
            d = $urandom_range(1, AL + 10);
            caught = (d <= AL + 8);
            case ($urandom_range(0, 2))
                0:       hi = SW'($urandom_range(0, 2047));
                1:       hi = ZERO + SW'($urandom_range(0, 300));
                default: hi = ZERO + SW'(sw_score(query, kept));
            endcase
            exp_score = (caught && hi >= ZERO) ? int'(hi) - int'(ZERO) : 0;
            exp_err   = (n > MAXT) || !caught;
            exp_lat   = caught ? d + 1 : AL + 9;
            clear_mon();
            vld_mode = 1'b1; vld_delay = d; vld_high = hi;
            send_target(b, g, st);
            wait_result(ok);
            bad = (en_q.size() != exp_len || en_runs != 1) ? 1 : 0;
            for (int i = 0; i < en_q.size() && i < exp_len; i++) if (en_q[i] !== kept[i]) bad++;
            tests_run++;
            if (!ok || bad != 0 || bnd_bad != 0 || idle_bad != 0) begin
                tests_failed++;
                $display("FAIL rand%0d_stream: ok=%b beats=%0d runs=%0d bad=%0d bnd=%0d idle=%0d, want 1 %0d 1 0 0 0",
                         it, ok, en_q.size(), en_runs, bad, bnd_bad, idle_bad, exp_len);
            end
            tests_run++;
            if (r_len !== TW'(exp_len) || r_err !== exp_err || r_score !== SW'(exp_score)) begin
                tests_failed++;
                $display("FAIL rand%0d_result: len=%0d err=%b score=%0d, want %0d %b %0d",
                         it, r_len, r_err, r_score, exp_len, exp_err, exp_score);
            end
            tests_run++;
            if (rv_cyc - gap_cyc != exp_lat) begin
                tests_failed++;
                $display("FAIL rand%0d_latency: gap-to-valid=%0d, want %0d", it, rv_cyc - gap_cyc, exp_lat);
            end
            consume("rand");
        end
    endtask

    initial begin
        rst = 1'b0; s_base = 2'b00; s_valid = 1'b0; s_last = 1'b0; r_ready = 1'b0;
        query = '{2'b00, 2'b11, 2'b01, 2'b10};
        test_reset();
        test_acgt();
        test_load_gaps();
        test_one_base();
        test_overflow();
        test_timeout();
        test_vld_expiry();
        test_reset_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
